// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if
// Bundles the FIFO user handshake, the status/error outputs and the
// external dual-port RAM port of ram_fifo_ctrl. The slave modport is the
// controller's view. The master modport is the view of whatever sits
// around it: the producer/consumer plus the RAM that returns read data.

interface ram_fifo_ctrl_if #(
  parameter int DATAWL = 8,
  parameter int ADDRWL = 8
);

  // user side
  logic              flush;
  logic              push;
  logic [DATAWL-1:0] din;
  logic              pop;
  logic [DATAWL-1:0] dout;
  logic              dout_valid;
  logic              clr_err;

  // status
  logic              full;
  logic              afull;
  logic              empty;
  logic              aempty;
  logic [ADDRWL:0]   count;
  logic              ovf;
  logic              unf;

  // RAM port
  logic              ram_we;
  logic [ADDRWL-1:0] ram_wa;
  logic [DATAWL-1:0] ram_wd;
  logic [ADDRWL-1:0] ram_ra;
  logic [DATAWL-1:0] ram_rd;

  modport slave (
    input  flush, push, din, pop, clr_err, ram_rd,
    output dout, dout_valid, full, afull, empty, aempty, count, ovf, unf,
           ram_we, ram_wa, ram_wd, ram_ra
  );

  modport master (
    output flush, push, din, pop, clr_err, ram_rd,
    input  dout, dout_valid, full, afull, empty, aempty, count, ovf, unf,
           ram_we, ram_wa, ram_wd, ram_ra
  );

endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// FIFO controller that runs an external dual-port RAM as a circular queue.
// The RAM has a registered read and no read enable, so the read address
// always presents rd_ptr. The word for a pop is therefore captured by the
// RAM at the same edge that accepts the pop, and it is valid for exactly
// one cycle after that edge.
// Accept decisions use only the registered flags. This means a full FIFO
// never accepts a push, even when a pop happens in the same cycle, and an
// empty FIFO never accepts a pop.

module ram_fifo_ctrl #(
  parameter int DATAWL    = 8,
  parameter int ADDRWL    = 8,
  parameter int AFULL_TH  = (1 << ADDRWL) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  ram_fifo_ctrl_if.slave   bus
);

  localparam int              DEPTH      = 1 << ADDRWL;
  localparam logic [ADDRWL:0] DEPTH_CNT  = (ADDRWL+1)'(DEPTH);
  localparam logic [ADDRWL:0] CNT_ONE    = (ADDRWL+1)'(1);
  localparam logic [ADDRWL-1:0] PTR_ONE  = ADDRWL'(1);
  // flag values for an empty queue (reset and flush)
  localparam logic AFULL_RST  = (AFULL_TH <= 0);
  localparam logic AEMPTY_RST = (AEMPTY_TH >= 0);

  logic [ADDRWL-1:0] wr_ptr;
  logic [ADDRWL-1:0] rd_ptr;
  logic [ADDRWL:0]   count_q;
  logic [ADDRWL:0]   count_next;
  logic              full_q;
  logic              afull_q;
  logic              empty_q;
  logic              aempty_q;
  logic              dout_valid_q;
  logic              ovf_q;
  logic              unf_q;
  logic              push_acc;
  logic              pop_acc;
  logic              push_err;
  logic              pop_err;

  // A request is accepted only when the registered flag permits it. Flush wins over everything.
  assign push_acc = bus.push & ~full_q  & ~bus.flush;
  assign pop_acc  = bus.pop  & ~empty_q & ~bus.flush;
  assign push_err = bus.push &  full_q  & ~bus.flush;
  assign pop_err  = bus.pop  &  empty_q & ~bus.flush;

  // RAM write port follows the accepted push. The read port always looks at the head entry.
  assign bus.ram_we = push_acc;
  assign bus.ram_wa = wr_ptr;
  assign bus.ram_wd = bus.din;
  assign bus.ram_ra = rd_ptr;

  assign bus.dout       = bus.ram_rd;
  assign bus.dout_valid = dout_valid_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.afull      = afull_q;
  assign bus.empty      = empty_q;
  assign bus.aempty     = aempty_q;
  assign bus.ovf        = ovf_q;
  assign bus.unf        = unf_q;

  // Next occupancy. A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count_q;
    if (push_acc && !pop_acc) begin
      count_next = count_q + CNT_ONE;
    end else if (pop_acc && !push_acc) begin
      count_next = count_q - CNT_ONE;
    end
  end

  // Pointers, count, status flags and the read-valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      afull_q      <= AFULL_RST;
      empty_q      <= 1'b1;
      aempty_q     <= AEMPTY_RST;
      dout_valid_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      afull_q      <= AFULL_RST;
      empty_q      <= 1'b1;
      aempty_q     <= AEMPTY_RST;
      dout_valid_q <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count_q      <= count_next;
      full_q       <= (count_next == DEPTH_CNT);
      empty_q      <= (count_next == '0);
      afull_q      <= (int'(count_next) >= AFULL_TH);
      aempty_q     <= (int'(count_next) <= AEMPTY_TH);
      dout_valid_q <= pop_acc;
    end
  end

  // Sticky error flags. A new error in the same cycle beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push_err) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_err) begin
        ovf_q <= 1'b0;
      end
      if (pop_err) begin
        unf_q <= 1'b1;
      end else if (bus.clr_err) begin
        unf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl
// Directed bench for ram_fifo_ctrl with DEPTH 8, AFULL_TH 6 and AEMPTY_TH 1.
// A behavioural registered-read RAM closes the loop. Inputs change 1 ns
// after each rising edge. Registered outputs are sampled at that same
// point. Combinational RAM write signals are sampled 1 ns later, which is
// still well before the next edge.

module tb_ram_fifo_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  ram_fifo_ctrl_if #(.DATAWL(8), .ADDRWL(3)) bus ();

  ram_fifo_ctrl #(
    .DATAWL(8), .ADDRWL(3), .AFULL_TH(6), .AEMPTY_TH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // external dual-port RAM with registered read and no read enable
  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_wa] <= bus.ram_wd;
    bus.ram_rd <= mem[bus.ram_ra];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.flush = 0; bus.push = 0; bus.pop = 0; bus.clr_err = 0; bus.din = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick;
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty got %b exp 1", bus.empty); end
    vectors++; if (bus.aempty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_aempty got %b exp 1", bus.aempty); end
    vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full got %b exp 0", bus.full); end
    vectors++; if (bus.afull !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_afull got %b exp 0", bus.afull); end
    vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_count got %0d exp 0", bus.count); end
    vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dout_valid got %b exp 0", bus.dout_valid); end
    vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ram_we got %b exp 0", bus.ram_we); end
    vectors++; if ({bus.ovf, bus.unf} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_err got %b exp 00", {bus.ovf, bus.unf}); end
  endtask

  task automatic test_fill;
    logic [3:0] exp_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.push = 1'b1;
      bus.din  = 8'(8'h10 + i);
      #1;
      vectors++; if (bus.ram_we !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_ram_we[%0d] got %b exp 1", i, bus.ram_we); end
      vectors++; if (bus.ram_wa !== 3'(i)) begin miscompares++; $display("[TB] FAIL fill_ram_wa[%0d] got %0d exp %0d", i, bus.ram_wa, i); end
      tick;
      exp_cnt = 4'(i + 1);
      vectors++; if (bus.count !== exp_cnt) begin miscompares++; $display("[TB] FAIL fill_count[%0d] got %0d exp %0d", i, bus.count, exp_cnt); end
      vectors++; if (bus.afull !== (i + 1 >= 6)) begin miscompares++; $display("[TB] FAIL fill_afull[%0d] got %b exp %b", i, bus.afull, (i + 1 >= 6)); end
      vectors++; if (bus.full !== (i == 7)) begin miscompares++; $display("[TB] FAIL fill_full[%0d] got %b exp %b", i, bus.full, (i == 7)); end
      vectors++; if (bus.aempty !== (i + 1 <= 1)) begin miscompares++; $display("[TB] FAIL fill_aempty[%0d] got %b exp %b", i, bus.aempty, (i + 1 <= 1)); end
      vectors++; if (bus.empty !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_empty[%0d] got %b exp 0", i, bus.empty); end
    end
    // ninth push into a full queue is dropped
    bus.din = 8'hFF;
    #1;
    vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_ram_we got %b exp 0", bus.ram_we); end
    tick;
    bus.push = 1'b0;
    vectors++; if (bus.ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag got %b exp 1", bus.ovf); end
    vectors++; if (bus.count !== 4'd8) begin miscompares++; $display("[TB] FAIL ovf_count got %0d exp 8", bus.count); end
    vectors++; if (bus.full !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_full got %b exp 1", bus.full); end
  endtask

  task automatic test_drain;
    bus.pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      vectors++; if (bus.dout_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_valid[%0d] got %b exp 1", i, bus.dout_valid); end
      vectors++; if (bus.dout !== 8'(8'h10 + i)) begin miscompares++; $display("[TB] FAIL drain_dout[%0d] got %h exp %h", i, bus.dout, 8'(8'h10 + i)); end
      vectors++; if (bus.count !== 4'(7 - i)) begin miscompares++; $display("[TB] FAIL drain_count[%0d] got %0d exp %0d", i, bus.count, 7 - i); end
    end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_empty got %b exp 1", bus.empty); end
    vectors++; if (bus.unf !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_unf_early got %b exp 0", bus.unf); end
    // one more pop on an empty queue
    tick;
    bus.pop = 1'b0;
    vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL unf_valid got %b exp 0", bus.dout_valid); end
    vectors++; if (bus.unf !== 1'b1) begin miscompares++; $display("[TB] FAIL unf_flag got %b exp 1", bus.unf); end
    vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("[TB] FAIL unf_count got %0d exp 0", bus.count); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 5; i++) begin
      bus.push = 1'b1; bus.din = 8'(8'h50 + i);
      tick;
    end
    bus.push = 1'b0;
    bus.pop  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      vectors++; if (bus.dout !== 8'(8'h50 + i)) begin miscompares++; $display("[TB] FAIL wrap_pre_dout[%0d] got %h exp %h", i, bus.dout, 8'(8'h50 + i)); end
    end
    bus.pop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.push = 1'b1; bus.din = 8'(8'hA0 + i);
      #1;
      vectors++; if (bus.ram_wa !== 3'((5 + i) % 8)) begin miscompares++; $display("[TB] FAIL wrap_ram_wa[%0d] got %0d exp %0d", i, bus.ram_wa, (5 + i) % 8); end
      tick;
    end
    bus.push = 1'b0;
    vectors++; if (bus.full !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_full got %b exp 1", bus.full); end
    bus.pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++; if (bus.ram_ra !== 3'((5 + i) % 8)) begin miscompares++; $display("[TB] FAIL wrap_ram_ra[%0d] got %0d exp %0d", i, bus.ram_ra, (5 + i) % 8); end
      tick;
      vectors++; if (bus.dout_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_valid[%0d] got %b exp 1", i, bus.dout_valid); end
      vectors++; if (bus.dout !== 8'(8'hA0 + i)) begin miscompares++; $display("[TB] FAIL wrap_dout[%0d] got %h exp %h", i, bus.dout, 8'(8'hA0 + i)); end
    end
    bus.pop = 1'b0;
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      bus.push = 1'b1; bus.din = 8'(8'hC0 + i);
      tick;
    end
    bus.pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.din = 8'(8'hC4 + i);
      tick;
      vectors++; if (bus.count !== 4'd4) begin miscompares++; $display("[TB] FAIL b2b_count[%0d] got %0d exp 4", i, bus.count); end
      vectors++; if (bus.dout_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_valid[%0d] got %b exp 1", i, bus.dout_valid); end
      vectors++; if (bus.dout !== 8'(8'hC0 + i)) begin miscompares++; $display("[TB] FAIL b2b_dout[%0d] got %h exp %h", i, bus.dout, 8'(8'hC0 + i)); end
      vectors++; if ({bus.full, bus.afull, bus.empty, bus.aempty} !== 4'b0000) begin miscompares++; $display("[TB] FAIL b2b_flags[%0d] got %b exp 0000", i, {bus.full, bus.afull, bus.empty, bus.aempty}); end
    end
  endtask

  task automatic test_flush;
    // queue holds CA..CD; bring it to 6 and then pop one to reach 5
    bus.pop = 1'b0;
    bus.din = 8'hCE; tick;
    bus.din = 8'hCF; tick;
    bus.push = 1'b0;
    vectors++; if (bus.afull !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_flush_afull got %b exp 1", bus.afull); end
    bus.pop = 1'b1;
    tick;
    vectors++; if (bus.dout !== 8'hCA) begin miscompares++; $display("[TB] FAIL pre_flush_dout got %h exp ca", bus.dout); end
    vectors++; if (bus.count !== 4'd5) begin miscompares++; $display("[TB] FAIL pre_flush_count got %0d exp 5", bus.count); end
    bus.flush = 1'b1; bus.push = 1'b1; bus.din = 8'hEE;
    #1;
    vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_ram_we got %b exp 0", bus.ram_we); end
    tick;
    bus.flush = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
    vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("[TB] FAIL flush_count got %0d exp 0", bus.count); end
    vectors++; if ({bus.full, bus.afull, bus.empty, bus.aempty} !== 4'b0011) begin miscompares++; $display("[TB] FAIL flush_flags got %b exp 0011", {bus.full, bus.afull, bus.empty, bus.aempty}); end
    vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_valid got %b exp 0", bus.dout_valid); end
    vectors++; if ({bus.ovf, bus.unf} !== 2'b11) begin miscompares++; $display("[TB] FAIL flush_err_kept got %b exp 11", {bus.ovf, bus.unf}); end
    vectors++; if ({bus.ram_wa, bus.ram_ra} !== 6'd0) begin miscompares++; $display("[TB] FAIL flush_ptrs got %h exp 0", {bus.ram_wa, bus.ram_ra}); end
    bus.clr_err = 1'b1;
    tick;
    bus.clr_err = 1'b0;
    vectors++; if ({bus.ovf, bus.unf} !== 2'b00) begin miscompares++; $display("[TB] FAIL clr_err got %b exp 00", {bus.ovf, bus.unf}); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      bus.push = 1'b1; bus.din = 8'(8'h30 + i);
      tick;
    end
    bus.push = 1'b0;
    vectors++; if (bus.count !== 4'd3) begin miscompares++; $display("[TB] FAIL mid_pre_count got %0d exp 3", bus.count); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("[TB] FAIL mid_rst_count got %0d exp 0", bus.count); end
    vectors++; if ({bus.empty, bus.aempty} !== 2'b11) begin miscompares++; $display("[TB] FAIL mid_rst_empty got %b exp 11", {bus.empty, bus.aempty}); end
    vectors++; if (bus.ram_wa !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_rst_ram_wa got %0d exp 0", bus.ram_wa); end
    #1 rst = 1'b0;
    bus.push = 1'b1; bus.din = 8'h77;
    #1;
    vectors++; if ({bus.ram_we, bus.ram_wa} !== 4'b1000) begin miscompares++; $display("[TB] FAIL post_rst_write got %b exp 1000", {bus.ram_we, bus.ram_wa}); end
    tick;
    bus.push = 1'b0;
    vectors++; if (bus.count !== 4'd1) begin miscompares++; $display("[TB] FAIL post_rst_count got %0d exp 1", bus.count); end
    bus.pop = 1'b1;
    tick;
    bus.pop = 1'b0;
    vectors++; if ({bus.dout_valid, bus.dout} !== 9'h177) begin miscompares++; $display("[TB] FAIL post_rst_dout got %h exp 177", {bus.dout_valid, bus.dout}); end
  endtask

  // run every scenario in order and report
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset;
    test_fill;
    test_drain;
    test_wrap;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences one external dual-port RAM (registered read, 1-cycle read latency, no read enable) as a circular queue.
- Owns the write/read pointers, occupancy count, status flags and sticky error flags.
- Drives the RAM write port (RAM_WE/WA/WD) and read address (RAM_RA); returns read data from RAM_RD.
- Both RAM clocks are tied to CLK.

Parameters:
DATAWL, 8, data word width; must match the RAM.
ADDRWL, 8, RAM address width; FIFO depth DEPTH = 2^ADDRWL.
AFULL_TH, 2^ADDRWL-2, AFULL asserted when count >= AFULL_TH.
AEMPTY_TH, 2, AEMPTY asserted when count <= AEMPTY_TH.

Ports:
CLK  in  1  single clock; also drives RAM WCLK and RCLK.
RST  in  1  asynchronous, active-high reset.
FLUSH  in  1  synchronous queue clear.
PUSH  in  1  write request.
DIN  in  DATAWL  write data.
POP  in  1  read request.
DOUT  out  DATAWL  read data; equals RAM_RD, valid while DOUT_VALID=1.
DOUT_VALID  out  1  registered; high the cycle after an accepted pop.
FULL / AFULL / EMPTY / AEMPTY  out  1 each  registered status flags.
COUNT  out  ADDRWL+1  registered occupancy, 0..DEPTH.
OVF / UNF  out  1 each  sticky overflow / underflow flags.
CLR_ERR  in  1  synchronous clear of OVF and UNF.
RAM_WE  out  1  RAM write enable.
RAM_WA  out  ADDRWL  RAM write address.
RAM_WD  out  DATAWL  RAM write data.
RAM_RA  out  ADDRWL  RAM read address.
RAM_RD  in  DATAWL  RAM registered read data.

Behaviour:
- Reset (async, RST=1):
  - wr_ptr, rd_ptr and COUNT = 0.
  - EMPTY=1, AEMPTY=1, FULL=0, AFULL=(AFULL_TH==0), OVF=0, UNF=0, DOUT_VALID=0.
  - RAM contents are not touched; reset mid-stream discards queued data logically.
- Acceptance:
  - push_acc = PUSH & ~FULL & ~FLUSH.
  - pop_acc = POP & ~EMPTY & ~FLUSH.
  - Decisions use registered flags only, so no push-through when full and no pop-through when empty.
- RAM drive:
  - RAM_WE = push_acc (combinational), RAM_WA = wr_ptr, RAM_WD = DIN.
  - RAM_RA = rd_ptr at all times.
- Pointers: wr_ptr += push_acc and rd_ptr += pop_acc, each wrapping modulo DEPTH (natural ADDRWL-bit rollover).
- Count:
  - COUNT_next = COUNT + push_acc - pop_acc; unchanged when both are accepted.
  - Never exceeds DEPTH and never goes below 0.
- Flags, all registered from COUNT_next:
  - FULL = (COUNT_next==DEPTH).
  - EMPTY = (COUNT_next==0).
  - AFULL = (COUNT_next>=AFULL_TH).
  - AEMPTY = (COUNT_next<=AEMPTY_TH).
- Read latency:
  - At the edge that accepts a pop, the RAM samples mem[old rd_ptr] into RAM_RD.
  - DOUT_VALID=1 for exactly the following cycle, with DOUT = that word.
  - Consumer must capture DOUT in that cycle; back-to-back pops give one valid word per cycle.
- Write-to-read latency:
  - A word written at edge k can be popped no earlier than the cycle after k, since EMPTY drops at k.
  - Its data appears after edge k+1.
  - No same-address read/write collision is possible.
- Errors:
  - PUSH while FULL (and FLUSH=0): data dropped, OVF<=1.
  - POP while EMPTY (and FLUSH=0): ignored, UNF<=1, DOUT_VALID stays 0.
  - OVF and UNF hold until CLR_ERR or RST.
  - If CLR_ERR coincides with a new error, the set wins.
- FLUSH:
  - Pointers and COUNT go to 0, flags return to reset values except OVF/UNF, and DOUT_VALID goes to 0 next cycle.
  - FLUSH overrides concurrent PUSH/POP: no RAM write, no error flagged.
- No FSM beyond the pointers and counter; all outputs except the RAM_W* nets and DOUT are flop outputs.

Test Plan:
- Bench config: ADDRWL=3 (DEPTH 8), DATAWL=8, AFULL_TH=6, AEMPTY_TH=1.
- Reset then idle -> EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, COUNT=0, DOUT_VALID=0, RAM_WE=0.
- Push 0x10..0x17 on consecutive cycles:
  - AFULL rises after the 6th push; FULL=1 and COUNT=8 after the 8th.
  - A 9th push of 0xFF gives RAM_WE=0 and OVF=1.
- Pop 8 times back-to-back from full:
  - DOUT_VALID=1 for 8 consecutive cycles with DOUT 0x10..0x17 in order.
  - EMPTY=1 after the last pop; a further pop sets UNF=1 with no DOUT_VALID.
- Wrap-around:
  - Push 5, pop 5, then push 0xA0..0xA7 then pop all.
  - RAM_WA/RAM_RA wrap 7->0 and the data order is preserved.
- Simultaneous push+pop at COUNT=4 for 10 cycles:
  - COUNT stays 4 and flags stay steady.
  - Data out matches data in delayed by 4 entries.
- FLUSH asserted with PUSH=1, POP=1 at COUNT=5:
  - Next cycle COUNT=0, EMPTY=1, RAM_WE=0 in the flush cycle, OVF/UNF unchanged.
  - Then CLR_ERR clears OVF and UNF.
- RST pulsed mid-stream at COUNT=3:
  - Outputs reset immediately, independent of clock.
  - After release, the first push lands at RAM_WA=0.
